// File: rtl/oup_ulpi_reg_ctrl.sv
// oup_ulpi_reg_ctrl: ULPI link-side PHY register read/write sequencer with RX CMD capture
module oup_ulpi_reg_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] ins_instruction_i,
  input  logic       ins_exec_i,
  output logic       ins_exec_done_o,
  output logic       ins_exec_aborted_o,
  output logic       busy_o,
  input  logic [7:0] phyreg_addr_i,
  input  logic [7:0] phyreg_data_i,
  output logic [7:0] phyreg_data_o,
  output logic       phyreg_data_load_o,
  output logic [7:0] rx_cmd_byte_o,
  output logic       rx_cmd_valid_o,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, TXCMD, TXDATA, STOP, RD_TURN, RD_DATA, RD_BACK, RXCMD, FINISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic rd, to_stop, to_stop_n, accept, done_n, aborted_n, load_n, rx_n, bad, expired;
  assign bad = ins_instruction_i > 8'h02 || phyreg_addr_i > 8'h3F;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign ulpi_data_oe_o = !ulpi_dir_i;
  assign ulpi_stp_o = state == STOP;
  assign busy_o = state != IDLE;
  assign ulpi_data_o = state == TXCMD ? {1'b1, rd, addr} : state == TXDATA ? wdata : 8'h00;
  always_comb begin
    state_n = state;
    to_stop_n = to_stop;
    accept = 1'b0;
    done_n = 1'b0;
    aborted_n = 1'b0;
    load_n = 1'b0;
    rx_n = 1'b0;
    case (state)
      IDLE:
        if (ulpi_dir_i) state_n = RXCMD;
        else if (ins_exec_i) begin
          if (bad) aborted_n = 1'b1;
          else if (ins_instruction_i == 8'h00) done_n = 1'b1;
          else begin
            accept = 1'b1;
            to_stop_n = 1'b0;
            state_n = TXCMD;
          end
        end
      TXCMD, TXDATA:
        if (ulpi_dir_i) begin
          aborted_n = 1'b1;
          state_n = RXCMD;
        end else if (ulpi_nxt_i) state_n = state == TXDATA ? STOP : rd ? RD_TURN : TXDATA;
        else if (expired) begin
          to_stop_n = 1'b1;
          state_n = STOP;
        end
      // a timed-out transmit still closes the bus with stp, then reports the abort
      STOP: begin
        aborted_n = to_stop;
        done_n = !to_stop;
        state_n = to_stop ? IDLE : FINISH;
      end
      RD_TURN:
        if (ulpi_dir_i) state_n = RD_DATA;
        else if (expired) begin
          aborted_n = 1'b1;
          state_n = IDLE;
        end
      RD_DATA: begin
        load_n = !ulpi_nxt_i;
        aborted_n = ulpi_nxt_i;
        state_n = ulpi_nxt_i ? RXCMD : RD_BACK;
      end
      RD_BACK:
        if (!ulpi_dir_i) begin
          done_n = 1'b1;
          state_n = FINISH;
        end else if (expired) begin
          aborted_n = 1'b1;
          state_n = IDLE;
        end
      RXCMD: begin
        rx_n = ulpi_dir_i && !ulpi_nxt_i && cnt != '0;
        state_n = ulpi_dir_i ? RXCMD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      to_stop <= 1'b0;
      rd <= 1'b0;
      addr <= '0;
      wdata <= '0;
      ins_exec_done_o <= 1'b0;
      ins_exec_aborted_o <= 1'b0;
      phyreg_data_load_o <= 1'b0;
      rx_cmd_valid_o <= 1'b0;
      phyreg_data_o <= '0;
      rx_cmd_byte_o <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : &cnt ? cnt : cnt + CW'(1);
      to_stop <= to_stop_n;
      ins_exec_done_o <= done_n;
      ins_exec_aborted_o <= aborted_n;
      phyreg_data_load_o <= load_n;
      rx_cmd_valid_o <= rx_n;
      if (accept) begin
        rd <= ins_instruction_i == 8'h02;
        addr <= phyreg_addr_i[5:0];
        wdata <= phyreg_data_i;
      end
      if (load_n) phyreg_data_o <= ulpi_data_i;
      if (rx_n) rx_cmd_byte_o <= ulpi_data_i;
    end
  end
endmodule

// File: doc/oup_ulpi_reg_ctrl.md
OUP_ULPI_REG_CTRL -- requirements
Module: oup_ulpi_reg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles waiting on any PHY response (nxt/dir) before abort.
REQ-002 SHALL have ports: ulpi_clk_i  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have: rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have: ins_instruction_i  in  8  opcode: 0x00 NOP, 0x01 REG_WRITE, 0x02 REG_READ.
REQ-005 SHALL have: ins_exec_i  in  1  start pulse, sampled only in IDLE.
REQ-006 SHALL have: ins_exec_done_o  out  1; ins_exec_aborted_o  out  1; busy_o  out  1.
REQ-007 SHALL have: phyreg_addr_i  in  8; phyreg_data_i  in  8  write data; phyreg_data_o  out  8  read data; phyreg_data_load_o  out  1.
REQ-008 SHALL have: rx_cmd_byte_o  out  8  last RX CMD; rx_cmd_valid_o  out  1.
REQ-009 SHALL have: ulpi_data_i  in  8; ulpi_data_o  out  8; ulpi_data_oe_o  out  1; ulpi_dir_i  in  1; ulpi_nxt_i  in  1; ulpi_stp_o  out  1.

Function
REQ-010 SHALL implement states IDLE, TXCMD, TXDATA, STOP, RD_TURN, RD_DATA, RD_BACK, RXCMD, FINISH.
REQ-011 SHALL drive ulpi_data_o=0x00 (idle) whenever no command/data is driven; ulpi_data_oe_o SHALL equal !ulpi_dir_i combinationally (never drive while dir high).
REQ-012 IDLE: on ins_exec_i=1 with dir low, latch opcode/addr/data and move to TXCMD next edge; busy_o high from that edge until return to IDLE.
REQ-013 NOP SHALL produce a one-cycle ins_exec_done_o pulse the cycle after exec, no bus activity.
REQ-014 Unknown opcode or phyreg_addr_i>0x3F SHALL produce a one-cycle ins_exec_aborted_o pulse the cycle after exec, no bus activity.
REQ-015 TXCMD: drive 0x80|addr[5:0] (write) or 0xC0|addr[5:0] (read), hold until ulpi_nxt_i sampled high; then write->TXDATA, read->RD_TURN.
REQ-016 TXDATA: drive latched write data, hold until nxt sampled high; then STOP.
REQ-017 STOP: ulpi_stp_o=1 for exactly one cycle with data 0x00; then FINISH.
REQ-018 RD_TURN: wait for dir high; first dir-high cycle is turnaround (data ignored); then RD_DATA.
REQ-019 RD_DATA: if nxt low, capture ulpi_data_i into phyreg_data_o, pulse phyreg_data_load_o one cycle, go RD_BACK; if nxt high, abort (PHY receive preempted read) and go RXCMD.
REQ-020 RD_BACK: wait for dir low (turnaround back), then FINISH.
REQ-021 FINISH: one-cycle ins_exec_done_o pulse, return IDLE.
REQ-022 dir sampled high in TXCMD or TXDATA SHALL abort: pulse ins_exec_aborted_o, stp not asserted, go RXCMD.
REQ-023 RXCMD (also entered from IDLE on dir high when no exec accepted): skip turnaround cycle; each later cycle with dir high and nxt low SHALL latch ulpi_data_i into rx_cmd_byte_o and pulse rx_cmd_valid_o; return IDLE one cycle after dir low.
REQ-024 Timeout counter SHALL reset on state entry; TIMEOUT_CYCLES cycles waiting in TXCMD, TXDATA, RD_TURN or RD_BACK SHALL pulse ins_exec_aborted_o and go IDLE (TX states assert stp one cycle first).
REQ-025 ins_exec_done_o and ins_exec_aborted_o SHALL never both be high; exactly one pulses per accepted non-ignored exec.
REQ-026 ins_exec_i while busy_o high SHALL be ignored.

Reset
REQ-027 rst_n_i low SHALL asynchronously force IDLE, all outputs 0 except ulpi_data_oe_o (=!ulpi_dir_i), rx_cmd_byte_o=0x00, phyreg_data_o=0x00, counter 0.
REQ-028 Reset mid-transaction SHALL abandon it with no done/aborted pulse after release.

Verification
REQ-029 Write addr 0x04 data 0x5A, PHY nxt after 2 cycles each -> bus 0x84 then 0x5A, stp 1 cycle, data 0x00, done pulse once.
REQ-030 Read addr 0x0A, PHY nxt, dir, turnaround, data 0x3C -> phyreg_data_o=0x3C, load pulse, done after dir low.
REQ-031 dir rises during TXDATA, RX CMD 0x4D follows -> aborted pulse, no stp, rx_cmd_byte_o=0x4D, oe low while dir high.
REQ-032 nxt never asserted -> aborted at TIMEOUT_CYCLES (64) cycles, stp one cycle, busy_o low after.
REQ-033 Opcode 0x07 and addr 0x41 -> aborted next cycle, bus stays 0x00, stp low.
REQ-034 rst_n_i low during RD_TURN -> outputs reset immediately, no done/aborted pulse, next write completes normally.
